// File: rtl/spi_cmd_pkg.sv
// Shared FSM state encoding, opcode/response constants and the opcode decoder
// used by the SPI command controller.
package spi_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_DATA = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_GET,
        CMD_WRITE,
        CMD_READ,
        CMD_ERR
    } cmd_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_ERR  = 8'hEE;
    localparam logic [1:0] PFX_WRITE = 2'b01;
    localparam logic [1:0] PFX_READ  = 2'b10;

    // Address bits above the register-file width must be zero for a legal access.
    function automatic cmd_t decode_cmd(input logic [7:0] op,
                                        input logic [7:0] get_op,
                                        input int         addr_w);
        logic [5:0] high_bits;
        cmd_t       cmd;
        high_bits = op[5:0] >> addr_w;
        if (op == get_op)
            cmd = CMD_GET;
        else if (op == OP_NOP)
            cmd = CMD_NOP;
        else if (high_bits != 6'd0)
            cmd = CMD_ERR;
        else if (op[7:6] == PFX_WRITE)
            cmd = CMD_WRITE;
        else if (op[7:6] == PFX_READ)
            cmd = CMD_READ;
        else
            cmd = CMD_ERR;
        return cmd;
    endfunction

endpackage

// File: rtl/spi_cmd_timeout.sv
// Loadable down-counter that strobes expire once it has been enabled for
// TIMEOUT_CYC cycles since the last load.
module spi_cmd_timeout #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expire
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= LOAD_VAL;
        else if (enable && (count != '0))
            count <= count - CNT_W'(1);
    end

    assign expire = enable && (count == '0);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder with a small control register file and state readback.
// Define SPI_CMD_CTRL_ERRCNT_EN to build the saturating protocol-error counter.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int         NUM_REGS      = 4,
    parameter int         TIMEOUT_CYC   = 1024,
    parameter logic [7:0] CMD_GET_STATE = 8'hFF
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_SPI_CS_n,
    input  logic [1:0]            i_State,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [8*NUM_REGS-1:0] o_Reg,
    output logic [7:0]            o_Err_Cnt
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    state_t            state;
    cmd_t              cmd;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rx_addr;
    logic [7:0]        reg_file [NUM_REGS];
    logic              to_load;
    logic              to_enable;
    logic              to_expire;

    assign cmd       = decode_cmd(i_RX_Byte, CMD_GET_STATE, ADDR_W);
    assign rx_addr   = i_RX_Byte[ADDR_W-1:0];
    assign to_load   = (state == ST_IDLE) && i_RX_DV && (cmd == CMD_WRITE);
    assign to_enable = (state == ST_WR_DATA);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign o_Reg[8*g +: 8] = reg_file[g];
    end

    spi_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .CLOCK_50 (i_Clk),
        .rst_n    (i_Rst_L),
        .load     (to_load),
        .enable   (to_enable),
        .expire   (to_expire)
    );

    // Every response passes through RESP, so TX pulses are always spaced and
    // a byte arriving while a response is being loaded is dropped.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= ST_IDLE;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++)
                reg_file[i] <= 8'h00;
        end else begin
            o_TX_DV <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_RX_DV) begin
                        case (cmd)
                            CMD_GET: begin
                                o_TX_Byte <= {6'b0, i_State};
                                o_TX_DV   <= 1'b1;
                                state     <= ST_RESP;
                            end
                            CMD_READ: begin
                                o_TX_Byte <= reg_file[rx_addr];
                                o_TX_DV   <= 1'b1;
                                state     <= ST_RESP;
                            end
                            CMD_WRITE: begin
                                wr_addr <= rx_addr;
                                state   <= ST_WR_DATA;
                            end
                            CMD_ERR: begin
                                o_TX_Byte <= RESP_ERR;
                                o_TX_DV   <= 1'b1;
                                state     <= ST_RESP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
                // A data byte wins over a simultaneous chip-select release.
                ST_WR_DATA: begin
                    if (i_RX_DV) begin
                        reg_file[wr_addr] <= i_RX_Byte;
                        o_TX_Byte         <= RESP_ACK;
                        o_TX_DV           <= 1'b1;
                        state             <= ST_RESP;
                    end else if (i_SPI_CS_n) begin
                        state <= ST_IDLE;
                    end else if (to_expire) begin
                        o_TX_Byte <= RESP_ERR;
                        o_TX_DV   <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_CMD_CTRL_ERRCNT_EN
    logic       err_event;
    logic [7:0] err_cnt;

    assign err_event = ((state == ST_IDLE) && i_RX_DV && (cmd == CMD_ERR)) ||
                       ((state == ST_WR_DATA) && !i_RX_DV && !i_SPI_CS_n && to_expire);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            err_cnt <= 8'h00;
        else if (err_event && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'h01;
    end

    assign o_Err_Cnt = err_cnt;
`else
    assign o_Err_Cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed literal cases plus a
// randomized run compared every cycle against a transaction-level model.
module tb_spi_cmd_ctrl;

    localparam int NUM_REGS    = 4;
    localparam int TIMEOUT_CYC = 1024;

    logic                  i_Clk      = 1'b0;
    logic                  i_Rst_L    = 1'b0;
    logic                  i_RX_DV    = 1'b0;
    logic [7:0]            i_RX_Byte  = 8'h00;
    logic                  i_SPI_CS_n = 1'b0;
    logic [1:0]            i_State    = 2'b00;
    logic                  o_TX_DV;
    logic [7:0]            o_TX_Byte;
    logic [8*NUM_REGS-1:0] o_Reg;
    logic [7:0]            o_Err_Cnt;

    int errors = 0;
    int checks = 0;

    always #5 i_Clk = ~i_Clk;

    spi_cmd_ctrl #(
        .NUM_REGS      (NUM_REGS),
        .TIMEOUT_CYC   (TIMEOUT_CYC),
        .CMD_GET_STATE (8'hFF)
    ) dut (
        .i_Clk      (i_Clk),
        .i_Rst_L    (i_Rst_L),
        .i_RX_DV    (i_RX_DV),
        .i_RX_Byte  (i_RX_Byte),
        .i_SPI_CS_n (i_SPI_CS_n),
        .i_State    (i_State),
        .o_TX_DV    (o_TX_DV),
        .o_TX_Byte  (o_TX_Byte),
        .o_Reg      (o_Reg),
        .o_Err_Cnt  (o_Err_Cnt)
    );

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: protocol rules applied per received byte.
    logic [7:0] m_regs [NUM_REGS];
    int         m_err     = 0;
    bit         m_tx_dv   = 1'b0;
    logic [7:0] m_tx_byte = 8'h00;
    bit         m_pending = 1'b0;
    int         m_addr    = 0;
    int         m_waited  = 0;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        forever begin
            @(posedge i_Clk or negedge i_Rst_L);
            if (!i_Rst_L) begin
                for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
                m_err = 0; m_tx_dv = 1'b0; m_tx_byte = 8'h00;
                m_pending = 1'b0; m_addr = 0; m_waited = 0;
            end else begin
                bit         was_pulse;
                logic [7:0] b;
                int         top;
                int         a;
                was_pulse = m_tx_dv;
                m_tx_dv   = 1'b0;
                b         = i_RX_Byte;
                top       = int'(b) / 64;
                a         = int'(b) % 64;
                if (was_pulse) begin
                    // byte arriving during a response is dropped
                end else if (m_pending) begin
                    if (i_RX_DV) begin
                        m_regs[m_addr] = b;
                        m_tx_dv = 1'b1; m_tx_byte = 8'hA5; m_pending = 1'b0;
                    end else if (i_SPI_CS_n) begin
                        m_pending = 1'b0;
                    end else begin
                        m_waited++;
                        if (m_waited == TIMEOUT_CYC) begin
                            m_tx_dv = 1'b1; m_tx_byte = 8'hEE; m_err++; m_pending = 1'b0;
                        end
                    end
                end else if (i_RX_DV) begin
                    if (b == 8'hFF) begin
                        m_tx_dv = 1'b1; m_tx_byte = {6'b0, i_State};
                    end else if (b == 8'h00) begin
                        // no operation
                    end else if ((top == 1 || top == 2) && a < NUM_REGS) begin
                        if (top == 1) begin
                            m_pending = 1'b1; m_addr = a; m_waited = 0;
                        end else begin
                            m_tx_dv = 1'b1; m_tx_byte = m_regs[a];
                        end
                    end else begin
                        m_tx_dv = 1'b1; m_tx_byte = 8'hEE; m_err++;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] expErrCnt(input int n);
`ifdef SPI_CMD_CTRL_ERRCNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return (n < 0) ? 8'h01 : 8'h00;
`endif
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        logic prev_dv;
        logic [8*NUM_REGS-1:0] exp_regs;
        prev_dv = 1'b0;
        forever begin
            @(negedge i_Clk);
            for (int i = 0; i < NUM_REGS; i++) exp_regs[8*i +: 8] = m_regs[i];
            checkOutput("tx_dv", o_TX_DV, m_tx_dv);
            checkOutput("tx_byte", o_TX_Byte, m_tx_byte);
            checkOutput("regs", o_Reg, exp_regs);
            checkOutput("err_cnt", o_Err_Cnt, expErrCnt(m_err));
            checkOutput("tx_dv_spacing", o_TX_DV & prev_dv, 1'b0);
            prev_dv = o_TX_DV;
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic [1:0] st);
        i_RX_Byte = b;
        i_State   = st;
        i_RX_DV   = 1'b1;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
    endtask

    function automatic logic [7:0] randByte();
        int kind;
        kind = $urandom_range(0, 9);
        case (kind)
            0:       return 8'hFF;
            1:       return 8'h00;
            2, 3, 4: return {2'b01, 6'($urandom_range(0, 5))};
            5, 6, 7: return {2'b10, 6'($urandom_range(0, 5))};
            8:       return 8'($urandom);
            default: return {2'b11, 6'($urandom_range(0, 62))};
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge i_Clk);
        checkOutput("reset_tx_dv", o_TX_DV, 1'b0);
        checkOutput("reset_tx_byte", o_TX_Byte, 8'h00);
        checkOutput("reset_regs", o_Reg, 32'h0);
        checkOutput("reset_err_cnt", o_Err_Cnt, 8'h00);
        #2 i_Rst_L = 1'b1;
        @(negedge i_Clk);

        // state readback
        applyStimulus(8'hFF, 2'b10);
        checkOutput("get_dv", o_TX_DV, 1'b1);
        checkOutput("get_byte", o_TX_Byte, 8'h02);
        @(negedge i_Clk);
        checkOutput("get_dv_single", o_TX_DV, 1'b0);

        // write then read back
        applyStimulus(8'h41, 2'b00);
        applyStimulus(8'h3C, 2'b00);
        checkOutput("wr_ack_dv", o_TX_DV, 1'b1);
        checkOutput("wr_ack_byte", o_TX_Byte, 8'hA5);
        checkOutput("wr_reg1", o_Reg[15:8], 8'h3C);
        @(negedge i_Clk);
        applyStimulus(8'h81, 2'b00);
        checkOutput("rd_dv", o_TX_DV, 1'b1);
        checkOutput("rd_byte", o_TX_Byte, 8'h3C);
        @(negedge i_Clk);

        // bad opcode
        applyStimulus(8'hC3, 2'b00);
        checkOutput("err_byte", o_TX_Byte, 8'hEE);
`ifdef SPI_CMD_CTRL_ERRCNT_EN
        checkOutput("err_cnt_one", o_Err_Cnt, 8'h01);
`else
        checkOutput("err_cnt_tied", o_Err_Cnt, 8'h00);
`endif
        @(negedge i_Clk);

        // data byte never arrives
        applyStimulus(8'h40, 2'b00);
        repeat (TIMEOUT_CYC - 1) @(negedge i_Clk);
        checkOutput("timeout_not_early", o_TX_DV, 1'b0);
        @(negedge i_Clk);
        checkOutput("timeout_dv", o_TX_DV, 1'b1);
        checkOutput("timeout_byte", o_TX_Byte, 8'hEE);
        checkOutput("timeout_reg0", o_Reg[7:0], 8'h00);
        @(negedge i_Clk);

        // chip select released while waiting for data
        applyStimulus(8'h40, 2'b00);
        repeat (9) @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        checkOutput("abort_no_tx", o_TX_DV, 1'b0);
        repeat (TIMEOUT_CYC + 10) @(negedge i_Clk);
`ifdef SPI_CMD_CTRL_ERRCNT_EN
        checkOutput("abort_no_err", o_Err_Cnt, 8'h02);
`else
        checkOutput("abort_no_err", o_Err_Cnt, 8'h00);
`endif
        applyStimulus(8'hFF, 2'b01);
        checkOutput("abort_idle_get", o_TX_Byte, 8'h01);
        checkOutput("abort_reg0", o_Reg[7:0], 8'h00);
        @(negedge i_Clk);

        // error counter saturation
        for (int i = 0; i < 256; i++) begin
            applyStimulus(8'hC3, 2'b00);
            @(negedge i_Clk);
        end
`ifdef SPI_CMD_CTRL_ERRCNT_EN
        checkOutput("err_cnt_sat", o_Err_Cnt, 8'hFF);
`else
        checkOutput("err_cnt_sat", o_Err_Cnt, 8'h00);
`endif

        // reset while a write is pending
        applyStimulus(8'h42, 2'b00);
        #2 i_Rst_L = 1'b0;
        #1;
        checkOutput("midwr_rst_dv", o_TX_DV, 1'b0);
        checkOutput("midwr_rst_byte", o_TX_Byte, 8'h00);
        checkOutput("midwr_rst_regs", o_Reg, 32'h0);
        checkOutput("midwr_rst_err", o_Err_Cnt, 8'h00);
        @(negedge i_Clk);
        #2 i_Rst_L = 1'b1;
        @(negedge i_Clk);
        applyStimulus(8'hFF, 2'b11);
        checkOutput("post_rst_get_dv", o_TX_DV, 1'b1);
        checkOutput("post_rst_get_byte", o_TX_Byte, 8'h03);
        @(negedge i_Clk);

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 4000; i++) begin
            i_RX_DV    = ($urandom_range(0, 9) < 4);
            i_RX_Byte  = randByte();
            i_State    = 2'($urandom);
            i_SPI_CS_n = ($urandom_range(0, 19) == 0);
            @(negedge i_Clk);
        end
        i_RX_DV    = 1'b0;
        i_SPI_CS_n = 1'b0;
        repeat (4) @(negedge i_Clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
